mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares a single N:1 word multiplexer between N requesters and sequences its select line. Each requester presents a word and holds `req` high. The arbiter grants one requester at a time, drives the mux select, and presents the selected word on a valid/ready output channel. It sits between the 16-input requester bank and the single shared downstream consumer.

## Interface
- `N`, 16, number of requesters / mux inputs (power of two, ≥2)
- `SELW`, 4, select width, log2(N)
- `W`, 8, data word width per requester
- `BURST`, 4, maximum accepted transfers per grant (only used with `MUX_RR_ARB_BURST_LIMIT_EN`)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  N  per-requester request; bit i high = requester i has data
- `in`  in  N*W  flattened data; word i = `in[i*W +: W]`
- `out_ready`  in  1  downstream accepts `out` this cycle
- `sel`  out  SELW  registered mux select (granted index)
- `gnt`  out  N  registered one-hot grant; all-zero when idle
- `out_valid`  out  1  `gnt` nonzero AND `req[sel]` high (combinational)
- `out`  out  W  word `in[sel*W +: W]` (combinational mux)
- `busy`  out  1  state is GRANT

## Operation
- Two states, IDLE and GRANT. Registers: `sel`, `gnt`, `last` (SELW, most recently released index), `bcnt` (beat counter, with macro only).
- IDLE: if `req` == 0, stay. Otherwise pick the first set `req` bit scanning `last+1, last+2, …` modulo N (wrap from N-1 to 0). Load `sel` with that index and `gnt` with its one-hot, clear `bcnt`, go to GRANT.
- GRANT: a transfer occurs in any cycle with `out_valid && out_ready`. Release when either of these holds:
  - `req[sel]` is sampled low, or
  - with the macro only, a transfer occurs while `bcnt == BURST-1`.
- On release: `last <= sel`, `gnt <= 0`, go to IDLE. `sel` holds its value while idle.
- On a transfer without release, `bcnt` increments (width ceil(log2(BURST))+1, no wrap within a grant).
- Changes to non-granted `req` bits during GRANT have no effect until the next IDLE arbitration.
- If only one requester is active, it is re-granted after each release, following the IDLE gap.
- `out_ready` high with `out_valid` low: no transfer, no counting.

## Timing
- Reset values: state IDLE, `sel`=0, `gnt`=0, `last`=N-1 (first scan starts at index 0), `bcnt`=0. Hence `out_valid`=0, `busy`=0, and `out` = word 0.
- Grant latency: `req` high in cycle t (state IDLE) → `gnt` and `sel` valid in cycle t+1.
- Release costs exactly one IDLE cycle. A new grant appears 2 cycles after the last transfer or after the cycle in which `req` drop was sampled.
- `out` and `out_valid` follow `in` and `req` combinationally within a granted cycle.
- Reset asserted mid-GRANT: the next edge forces reset values and drops any partially used burst. The fairness pointer returns to `last`=N-1.
- `rst` has priority over all other inputs.

## Configuration
- `MUX_RR_ARB_BURST_LIMIT_EN` defined:
  - `bcnt` is present.
  - A grant is released after `BURST` accepted transfers even if `req[sel]` stays high.
  - The next scan starts after `sel`, giving bounded latency: with `BURST`=4, N=16 and all requesters active, a requester waits at most 15×5 cycles when `out_ready` is constantly high.
- Undefined:
  - No `bcnt` register and no `BURST` check.
  - A grant is held until the requester drops `req`.
  - The `BURST` parameter is ignored.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=16'hFFFF → `gnt`=0, `sel`=0, `out_valid`=0, `busy`=0. First cycle after release of `rst` → `gnt`=16'h0001, `sel`=0.
- Rotation: `req`=16'h2204 held, `out_ready`=1, macro on with `BURST`=4 → grants in order 2, 9, 13, 2. Each grant lasts 4 cycles, followed by 1 IDLE cycle.
- Requester drop: only `req[5]`=1, `in` word 5 = 8'hA5, `out_ready`=1; drop `req[5]` after 2 cycles of valid → exactly 2 transfers of 8'hA5. Next cycle `busy`=0 and `last`=5.
- Backpressure: granted requester 7, `out_ready`=0 for 6 cycles → `out_valid`=1, `sel`=7 held, no `bcnt` change. Then `out_ready`=1 → 4 transfers, then release.
- Wrap-around: `last`=15, `req`=16'h8001 → next grant index 0, then 15.
- Mid-grant reset: `rst` pulsed during the 2nd beat of a grant to index 3 → next cycle `gnt`=0 and `last`=15. With `req`=16'h0009 still high, the next grant is index 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N:1 word mux onto a valid/ready channel.
// Define MUX_RR_ARB_BURST_LIMIT_EN to release each grant after BURST transfers.
module mux_rr_arbiter #(
    parameter int N     = 16,
    parameter int SELW  = 4,
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  in,
    input  logic            out_ready,
    output logic [SELW-1:0] sel,
    output logic [N-1:0]    gnt,
    output logic            out_valid,
    output logic [W-1:0]    out,
    output logic            busy
);

    if (N != (1 << SELW) || BURST < 1) begin : g_cfg_check
        $error("mux_rr_arbiter: N must equal 2**SELW and BURST must be >= 1");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t          state;
    logic [SELW-1:0] last;
    logic [SELW-1:0] pick;
    logic            found;
    logic            done;

    assign out_valid = (gnt != '0) && req[sel];
    assign out       = in[sel*W +: W];
    assign busy      = (state == GRANT);

    // Scan starts just after the last released index; SELW-bit add wraps.
    always_comb begin
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[last + SELW'(k)]) begin
                found = 1'b1;
                pick  = last + SELW'(k);
            end
        end
    end

`ifdef MUX_RR_ARB_BURST_LIMIT_EN
    localparam int BCW = $clog2(BURST) + 1;
    localparam logic [BCW-1:0] BLAST = BCW'(BURST - 1);

    logic [BCW-1:0] bcnt;
    logic           xfer;

    assign xfer = out_valid && out_ready;
    assign done = !req[sel] || (xfer && bcnt == BLAST);
`else
    assign done = !req[sel];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            last  <= SELW'(N - 1);
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
            bcnt  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= pick;
                        gnt   <= ONE << pick;
                        state <= GRANT;
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
                        bcnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (done) begin
                        last  <= sel;
                        gnt   <= '0;
                        state <= IDLE;
                    end
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
                    else if (xfer) begin
                        bcnt <= bcnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: inline checks plus a transfer scoreboard.
// Expectations follow MUX_RR_ARB_BURST_LIMIT_EN where behaviour differs.
module tb_mux_rr_arbiter;

    localparam int N = 16;
    localparam int SELW = 4;
    localparam int W = 8;
    localparam int BURST = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  in_bus;
    logic            out_ready;
    logic [SELW-1:0] sel;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [W-1:0]    out;
    logic            busy;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    mux_rr_arbiter #(
        .N(N), .SELW(SELW), .W(W), .BURST(BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .in(in_bus),
        .out_ready(out_ready),
        .sel(sel),
        .gnt(gnt),
        .out_valid(out_valid),
        .out(out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(int i);
        logic [3:0] n;
        n = 4'(i);
        return {~n, n};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted transfer must match the next expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL xfer_unexpected observed=%0h expected=none", out);
            end
            if (sb.size() != 0) begin
                logic [W-1:0] e;
                e = sb.pop_front();
                assert (out === e) else begin
                    failures++;
                    $error("FAIL xfer_word observed=%0h expected=%0h", out, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_cyc(int g, bit rdy);
        out_ready = rdy;
        if (rdy) sb.push_back(word(g));
        @(negedge clk);
        chk("grant_sel", 32'(sel), 32'(g));
        chk("grant_gnt", 32'(gnt), 32'(1) << g);
        chk("grant_valid", 32'(out_valid), 32'd1);
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_out", 32'(out), 32'(word(g)));
        step();
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        step();
    endtask

    task automatic rel_cyc();
        @(negedge clk);
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_bus[i*W +: W] = word(i);
        rst = 1'b1;
        req = 16'hFFFF;
        out_ready = 1'b0;

        // Reset held two cycles with all requests high
        step();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'(out), 32'(word(0)));
        step();
        rst = 1'b0;
        idle_cyc();
        grant_cyc(0, 1'b0);
        req = 16'h0000;
        rel_cyc();

        // Requester drop after two transfers
        req = 16'h0020;
        out_ready = 1'b1;
        idle_cyc();
        grant_cyc(5, 1'b1);
        grant_cyc(5, 1'b1);
        req = 16'h0000;
        rel_cyc();
        req = 16'h0021;
        idle_cyc();
        grant_cyc(0, 1'b0);
        req = 16'h0000;
        rel_cyc();

        // Wrap-around from index 15
        req = 16'h8000;
        idle_cyc();
        grant_cyc(15, 1'b0);
        req = 16'h0000;
        rel_cyc();
        req = 16'h8001;
        idle_cyc();
        grant_cyc(0, 1'b0);
        req = 16'h8000;
        rel_cyc();
        idle_cyc();
        grant_cyc(15, 1'b0);
        req = 16'h0000;
        rel_cyc();

        // Rotation across 2, 9, 13, 2
        req = 16'h2204;
        idle_cyc();
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
        for (int b = 0; b < BURST; b++) grant_cyc(2, 1'b1);
        idle_cyc();
        for (int b = 0; b < BURST; b++) grant_cyc(9, 1'b1);
        idle_cyc();
        for (int b = 0; b < BURST; b++) grant_cyc(13, 1'b1);
        idle_cyc();
        for (int b = 0; b < BURST; b++) grant_cyc(2, 1'b1);
        req = 16'h0000;
        idle_cyc();
`else
        for (int b = 0; b < 3; b++) grant_cyc(2, 1'b1);
        req = 16'h2206;
        for (int b = 0; b < 3; b++) grant_cyc(2, 1'b1);
        req = 16'h2200;
        rel_cyc();
        idle_cyc();
        grant_cyc(9, 1'b1);
        grant_cyc(9, 1'b1);
        req = 16'h2004;
        rel_cyc();
        idle_cyc();
        grant_cyc(13, 1'b1);
        grant_cyc(13, 1'b1);
        req = 16'h0204;
        rel_cyc();
        idle_cyc();
        grant_cyc(2, 1'b1);
        grant_cyc(2, 1'b1);
        req = 16'h0000;
        rel_cyc();
        idle_cyc();
`endif

        // Reset during the second beat of a grant to index 3
        req = 16'h0008;
        out_ready = 1'b1;
        idle_cyc();
        grant_cyc(3, 1'b1);
        rst = 1'b1;
        req = 16'h0009;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        idle_cyc();
        grant_cyc(0, 1'b0);
        req = 16'h0000;
        rel_cyc();

        // Backpressure on requester 7, then four accepted beats
        req = 16'h0080;
        idle_cyc();
        for (int b = 0; b < 6; b++) grant_cyc(7, 1'b0);
        for (int b = 0; b < 4; b++) grant_cyc(7, 1'b1);
        req = 16'h0000;
        @(negedge clk);
        chk("bp_end_valid", 32'(out_valid), 32'd0);
        step();
        idle_cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
